// File: rtl/sad_pkg.sv
// Shared definitions for the stereo SAD path: the default window, pixel and
// disparity sizes, plus the width derivations that the line buffer, the SAD
// engine and the disparity-map writer all need to agree on.
package sad_pkg;

    // Ceiling log2. Returns 0 for inputs of 0 or 1.
    function automatic int sad_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a window SAD. A sum of WIN*WIN DATA_SIZE-bit terms never overflows this width.
    function automatic int sad_width(input int win, input int data_size);
        return data_size + sad_clog2(win * win);
    endfunction

    localparam int SAD_DEF_WIN       = 3;
    localparam int SAD_DEF_DATA_SIZE = 8;
    localparam int SAD_DEF_MAX_DISP  = 16;
    localparam int SAD_DEF_WIN_SIZE  = SAD_DEF_WIN * SAD_DEF_WIN;
    localparam int SAD_DEF_SAD_W     = sad_width(SAD_DEF_WIN, SAD_DEF_DATA_SIZE);
    localparam int SAD_DEF_DISP_W    = sad_clog2(SAD_DEF_MAX_DISP);

endpackage

// File: rtl/sad_adder_tree.sv
// Pipelined binary adder tree with clock enable and a valid/tag sideband.
// Sums N unsigned IN_W-bit operands in $clog2(N) registered levels. A level
// with an odd operand count pairs its last operand with zero.
module sad_adder_tree
    import sad_pkg::*;
#(
    parameter int N     = 9,
    parameter int IN_W  = 8,
    parameter int TAG_W = 4,
    localparam int L     = sad_clog2(N),
    localparam int OUT_W = IN_W + L
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                vld_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic [N*IN_W-1:0]   data_i,
    output logic                vld_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [OUT_W-1:0]    sum_o
);

    localparam int W2 = 2 * N;

    // Number of live operands at tree level k (level 0 is the input row).
    function automatic int lvl_cnt(input int k);
        return (N + (1 << k) - 1) >> k;
    endfunction

    logic [OUT_W-1:0] node_q [1:L][0:N-1];
    logic [OUT_W-1:0] node_d [1:L][0:N-1];
    logic [OUT_W-1:0] view   [0:L][0:W2-1];
    logic             vld_q  [1:L];
    logic [TAG_W-1:0] tag_q  [1:L];

    // Zero-padded view of every level so pairwise sums never read a dead slot.
    always_comb begin
        for (int k = 0; k <= L; k++) begin
            for (int j = 0; j < W2; j++) begin
                view[k][j] = '0;
            end
        end
        for (int j = 0; j < N; j++) begin
            view[0][j] = OUT_W'(data_i[j*IN_W +: IN_W]);
        end
        for (int k = 1; k <= L; k++) begin
            for (int j = 0; j < N; j++) begin
                view[k][j] = (j < lvl_cnt(k)) ? node_q[k][j] : '0;
            end
        end
    end

    // Pairwise sums feeding the next register level.
    always_comb begin
        for (int k = 1; k <= L; k++) begin
            for (int j = 0; j < N; j++) begin
                node_d[k][j] = view[k-1][2*j] + view[k-1][2*j+1];
            end
        end
    end

    // Tree data registers: advance only when the engine is not stalled.
    always_ff @(posedge clk) begin
        if (en_i) begin
            node_q <= node_d;
        end
    end

    // Sideband shift: valid is cleared by reset, tag rides along with the data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= L; k++) begin
                vld_q[k] <= 1'b0;
            end
        end else if (en_i) begin
            vld_q[1] <= vld_i;
            for (int k = 2; k <= L; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // Tag shift, no reset needed: it is only looked at when the matching valid is set.
    always_ff @(posedge clk) begin
        if (en_i) begin
            tag_q[1] <= tag_i;
            for (int k = 2; k <= L; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign vld_o = vld_q[L];
    assign tag_o = tag_q[L];
    assign sum_o = node_q[L][0];

endmodule

// File: rtl/sad_disparity_search.sv
// SAD engine with winner-take-all disparity search. One window pair per cycle,
// one beat per candidate disparity; every MAX_DISP beats it emits the
// disparity with the lowest SAD and that SAD.
// Build option: define SAD_TIE_FAR_EN to make equal SADs resolve to the
// larger disparity (default: the smaller one wins).
module sad_disparity_search
    import sad_pkg::*;
#(
    parameter int WIN       = SAD_DEF_WIN,
    parameter int DATA_SIZE = SAD_DEF_DATA_SIZE,
    parameter int MAX_DISP  = SAD_DEF_MAX_DISP,
    localparam int WIN_SIZE = WIN * WIN,
    localparam int SAD_W    = DATA_SIZE + sad_clog2(WIN_SIZE),
    localparam int DISP_W   = sad_clog2(MAX_DISP)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_SIZE*WIN_SIZE-1:0] input_a,
    input  logic [DATA_SIZE*WIN_SIZE-1:0] input_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DISP_W-1:0]             out_disp,
    output logic [SAD_W-1:0]              out_sad
);

    localparam logic [DISP_W-1:0] LAST_D = DISP_W'(MAX_DISP - 1);

    function automatic logic [DATA_SIZE-1:0] abs_diff(input logic [DATA_SIZE-1:0] a,
                                                      input logic [DATA_SIZE-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic                          en;
    logic                          accept;
    logic [DISP_W-1:0]             d_cnt_q, d_cnt_d;
    logic [DATA_SIZE*WIN_SIZE-1:0] diff_p1_d, diff_p1_q;
    logic                          vld_p1_q;
    logic [DISP_W-1:0]             tag_p1_q;
    logic                          vld_t;
    logic [DISP_W-1:0]             tag_t;
    logic [SAD_W-1:0]              sum_t;
    logic                          better;
    logic                          take;
    logic                          final_hit;
    logic [SAD_W-1:0]              best_sad_q, best_sad_d;
    logic [DISP_W-1:0]             best_disp_q, best_disp_d;
    logic                          out_valid_q, out_valid_d;
    logic [DISP_W-1:0]             out_disp_q, out_disp_d;
    logic [SAD_W-1:0]              out_sad_q, out_sad_d;

    // Stall whenever a result is parked at the output; the whole pipe freezes with it.
    always_comb begin
        en      = !(out_valid_q && !out_ready);
        accept  = in_valid && en;
        d_cnt_d = d_cnt_q;
        if (accept) begin
            d_cnt_d = (d_cnt_q == LAST_D) ? '0 : d_cnt_q + 1'b1;
        end
    end

    assign in_ready = en;

    // Per-pixel absolute differences for the abs-diff register stage.
    always_comb begin
        diff_p1_d = '0;
        for (int i = 0; i < WIN_SIZE; i++) begin
            diff_p1_d[i*DATA_SIZE +: DATA_SIZE] =
                abs_diff(input_a[i*DATA_SIZE +: DATA_SIZE], input_b[i*DATA_SIZE +: DATA_SIZE]);
        end
    end

    // ---- stage 1: abs-diff register ----
    always_ff @(posedge clk) begin
        if (en) begin
            diff_p1_q <= diff_p1_d;
            tag_p1_q  <= d_cnt_q;
        end
    end

    sad_adder_tree #(
        .N     (WIN_SIZE),
        .IN_W  (DATA_SIZE),
        .TAG_W (DISP_W)
    ) u_tree (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en),
        .vld_i  (vld_p1_q),
        .tag_i  (tag_p1_q),
        .data_i (diff_p1_q),
        .vld_o  (vld_t),
        .tag_o  (tag_t),
        .sum_o  (sum_t)
    );

    // ---- compare stage: running minimum, final candidate loads the output ----
    always_comb begin
`ifdef SAD_TIE_FAR_EN
        better = (sum_t <= best_sad_q);
`else
        better = (sum_t < best_sad_q);
`endif
        take        = (tag_t == '0) || better;
        best_sad_d  = take ? sum_t : best_sad_q;
        best_disp_d = take ? tag_t : best_disp_q;
        final_hit   = en && vld_t && (tag_t == LAST_D);

        out_valid_d = out_valid_q;
        out_disp_d  = out_disp_q;
        out_sad_d   = out_sad_q;
        if (final_hit) begin
            out_valid_d = 1'b1;
            out_disp_d  = best_disp_d;
            out_sad_d   = best_sad_d;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Running-best registers; a d==0 candidate always overwrites, so no reset is needed.
    always_ff @(posedge clk) begin
        if (en && vld_t) begin
            best_sad_q  <= best_sad_d;
            best_disp_q <= best_disp_d;
        end
    end

    // Control state and the output register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_cnt_q     <= '0;
            vld_p1_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_disp_q  <= '0;
            out_sad_q   <= '0;
        end else begin
            d_cnt_q     <= d_cnt_d;
            out_valid_q <= out_valid_d;
            out_disp_q  <= out_disp_d;
            out_sad_q   <= out_sad_d;
            if (en) begin
                vld_p1_q <= in_valid;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_disp  = out_disp_q;
    assign out_sad   = out_sad_q;

endmodule
